// File: rtl/arithmetic_pkg.sv
// Shared width helpers and types for the posit significand adder.
// Purpose : derived widths computed from the posit size N and the exponent width ES.
// Contents: clog2_f, rs_w, scale_w, sig_w, sum_w, op_e.
package arithmetic_pkg;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Regime value field width minus one.
  function automatic int unsigned rs_w(input int unsigned n);
    return clog2_f(n);
  endfunction

  // Signed scale width: regime * 2^ES + exponent, plus one guard bit.
  function automatic int unsigned scale_w(input int unsigned n, input int unsigned es);
    return rs_w(n) + es + 2;
  endfunction

  // Significand width: hidden bit plus the mantissa.
  function automatic int unsigned sig_w(input int unsigned n, input int unsigned es);
    return n - es + 4;
  endfunction

  // Sum width: significand plus the carry bit.
  function automatic int unsigned sum_w(input int unsigned n, input int unsigned es);
    return n - es + 5;
  endfunction

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/arithmetic_align.sv
// Operand ordering and alignment for the significand adder.
// Purpose : choose the large operand (higher scale, then larger significand,
//           then operand 1) and right-shift the small significand by the
//           scale difference. A zero operand is never picked as large, so
//           the other operand passes through unchanged.
// Ports   : scale1/scale2 signed scales, sig1/sig2 significands,
//           zero1/zero2 zero flags, sig_l_c large significand,
//           sig_s_c aligned small significand (combinational).
// Config  : ARITH_STICKY_EN folds shifted-out bits into bit 0 of sig_s_c.
module arithmetic_align
  import arithmetic_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned ES = 3,
  localparam int unsigned SCW = scale_w(N, ES),
  localparam int unsigned SGW = sig_w(N, ES)
) (
  input  logic signed [SCW-1:0] scale1,
  input  logic signed [SCW-1:0] scale2,
  input  logic        [SGW-1:0] sig1,
  input  logic        [SGW-1:0] sig2,
  input  logic                  zero1,
  input  logic                  zero2,
  output logic        [SGW-1:0] sig_l_c,
  output logic        [SGW-1:0] sig_s_c
);

  logic                  swap;
  logic signed [SCW-1:0] scale_l;
  logic signed [SCW-1:0] scale_s;
  logic        [SGW-1:0] sig_s;
  logic        [SCW:0]   shamt;

  // Operand 2 becomes large only when it strictly wins, or operand 1 is zero.
  always_comb begin
    swap = zero1 || (!zero2 && ((scale2 > scale1) ||
                                ((scale2 == scale1) && (sig2 > sig1))));
  end

  always_comb begin
    scale_l = swap ? scale2 : scale1;
    scale_s = swap ? scale1 : scale2;
    sig_l_c = swap ? sig2   : sig1;
    sig_s   = swap ? sig1   : sig2;
  end

  // Sign-extended difference; non-negative whenever sig_s is nonzero.
  always_comb begin
    shamt = {scale_l[SCW-1], scale_l} - {scale_s[SCW-1], scale_s};
  end

`ifdef ARITH_STICKY_EN
  logic [SGW-1:0] lost;

  // Bits that fall off the right end collapse into a sticky bit.
  always_comb begin
    lost    = sig_s & ~({SGW{1'b1}} << shamt);
    sig_s_c = (sig_s >> shamt) | SGW'(|lost);
  end
`else
  // Shifts of SGW or more naturally produce zero.
  always_comb begin
    sig_s_c = sig_s >> shamt;
  end
`endif

endmodule

// File: rtl/arithmetic.sv
// Posit significand adder, one-cycle latency, throughput one per clock.
// Purpose : build scale and significand for both operands, align the smaller
//           operand, add or subtract by sign, and register the top N bits of
//           the un-normalised sum.
// Ports   : clk, reset (async, active-high), InRemain1/2 posit body without
//           sign, Sign1/2, RegimeValue1/2 decoded regime k, Exponent1/2,
//           Mantissa1/2 left-aligned fraction, Add_Mant registered result.
// Config  : ARITH_STICKY_EN enables the sticky bit in the aligner.
module arithmetic
  import arithmetic_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned ES = 3,
  localparam int unsigned RS   = rs_w(N),
  localparam int unsigned MW   = N - ES + 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [N-2:0] InRemain1,
  input  logic signed [N-2:0] InRemain2,
  input  logic               Sign1,
  input  logic               Sign2,
  input  logic signed [RS:0] RegimeValue1,
  input  logic signed [RS:0] RegimeValue2,
  input  logic      [ES-1:0] Exponent1,
  input  logic      [ES-1:0] Exponent2,
  input  logic      [MW-1:0] Mantissa1,
  input  logic      [MW-1:0] Mantissa2,
  output logic       [N-1:0] Add_Mant
);

  localparam int unsigned SCW  = scale_w(N, ES);
  localparam int unsigned SGW  = sig_w(N, ES);
  localparam int unsigned SUMW = sum_w(N, ES);

  logic signed [SCW-1:0] scale1;
  logic signed [SCW-1:0] scale2;
  logic                  zero1;
  logic                  zero2;
  logic        [SGW-1:0] sig1;
  logic        [SGW-1:0] sig2;
  logic        [SGW-1:0] sig_l;
  logic        [SGW-1:0] sig_s;
  op_e                   op;
  logic       [SUMW-1:0] sum_c;
  logic          [N-1:0] mant_c;

  // Exponent < 2^ES, so k*2^ES + e is just {k, e}, sign-extended one bit.
  always_comb begin
    scale1 = {RegimeValue1[RS], RegimeValue1, Exponent1};
    scale2 = {RegimeValue2[RS], RegimeValue2, Exponent2};
    zero1  = ~|InRemain1;
    zero2  = ~|InRemain2;
    sig1   = {~zero1, Mantissa1};
    sig2   = {~zero2, Mantissa2};
  end

  arithmetic_align #(
    .N  (N),
    .ES (ES)
  ) u_align (
    .scale1  (scale1),
    .scale2  (scale2),
    .sig1    (sig1),
    .sig2    (sig2),
    .zero1   (zero1),
    .zero2   (zero2),
    .sig_l_c (sig_l),
    .sig_s_c (sig_s)
  );

  // Large operand is never smaller than the aligned small one, so no borrow out.
  always_comb begin
    op = (Sign1 == Sign2) ? OP_ADD : OP_SUB;
    if (op == OP_ADD) sum_c = SUMW'(sig_l) + SUMW'(sig_s);
    else              sum_c = SUMW'(sig_l) - SUMW'(sig_s);
    mant_c = N'(sum_c >> (SUMW - N));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) Add_Mant <= '0;
    else       Add_Mant <= mant_c;
  end

endmodule

// File: tb/tb_arithmetic.sv
// Scoreboard bench for arithmetic at N=8, ES=3 (Add_Mant = Sum[9:2]).
module tb_arithmetic;

  logic              clk;
  logic              reset;
  logic signed [6:0] InRemain1, InRemain2;
  logic              Sign1, Sign2;
  logic signed [3:0] RegimeValue1, RegimeValue2;
  logic        [2:0] Exponent1, Exponent2;
  logic        [7:0] Mantissa1, Mantissa2;
  logic        [7:0] Add_Mant;

  arithmetic #(.N(8), .ES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .InRemain1    (InRemain1),
    .InRemain2    (InRemain2),
    .Sign1        (Sign1),
    .Sign2        (Sign2),
    .RegimeValue1 (RegimeValue1),
    .RegimeValue2 (RegimeValue2),
    .Exponent1    (Exponent1),
    .Exponent2    (Exponent2),
    .Mantissa1    (Mantissa1),
    .Mantissa2    (Mantissa2),
    .Add_Mant     (Add_Mant)
  );

  int          tests;
  int          fails;
  logic        issue_v;
  logic        mon_fire;
  logic  [7:0] q_exp[$];
  string       q_name[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair at the falling edge and queue its expected result.
  task automatic drive(input string name,
                       input logic [6:0] ir1, input logic s1, input logic [3:0] k1,
                       input logic [2:0] e1, input logic [7:0] m1,
                       input logic [6:0] ir2, input logic s2, input logic [3:0] k2,
                       input logic [2:0] e2, input logic [7:0] m2,
                       input logic [7:0] exp_v);
    @(negedge clk);
    InRemain1 = ir1; Sign1 = s1; RegimeValue1 = k1; Exponent1 = e1; Mantissa1 = m1;
    InRemain2 = ir2; Sign2 = s2; RegimeValue2 = k2; Exponent2 = e2; Mantissa2 = m2;
    issue_v = 1'b1;
    q_exp.push_back(exp_v);
    q_name.push_back(name);
  endtask

  task automatic check_now(input string name, input logic [7:0] exp_v);
    tests++;
    if (Add_Mant !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, Add_Mant, exp_v);
    end
  endtask

  // Monitor: an operand pair latched at a rising edge is checked 1 time unit later.
  always begin
    logic [7:0] e;
    string      n;
    @(posedge clk);
    mon_fire = issue_v && !reset;
    #1;
    if (mon_fire) begin
      tests++;
      if (q_exp.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got 0x%02h expected no result", Add_Mant);
      end else begin
        e = q_exp.pop_front();
        n = q_name.pop_front();
        if (Add_Mant !== e) begin
          fails++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", n, Add_Mant, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] sticky_exp;
    tests = 0; fails = 0;
    reset = 1'b1; issue_v = 1'b0;
    InRemain1 = '0; Sign1 = 1'b0; RegimeValue1 = '0; Exponent1 = '0; Mantissa1 = '0;
    InRemain2 = '0; Sign2 = 1'b0; RegimeValue2 = '0; Exponent2 = '0; Mantissa2 = '0;
    #1;
    check_now("reset_state", 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Back-to-back directed vectors, one per clock.
    drive("zero_zero",   7'h00, 0, 4'h0, 3'd0, 8'h00,  7'h00, 0, 4'h0, 3'd0, 8'h00, 8'h00);
    drive("add_diff3",   7'h72, 0, 4'h2, 3'd2, 8'h00,  7'h6E, 0, 4'h1, 3'd7, 8'h00, 8'h48);
    drive("sub_diff3",   7'h72, 0, 4'h2, 3'd2, 8'h00,  7'h6E, 1, 4'h1, 3'd7, 8'h00, 8'h38);
    drive("equal_add",   7'h40, 0, 4'h0, 3'd0, 8'h00,  7'h40, 0, 4'h0, 3'd0, 8'h00, 8'h80);
    drive("equal_sub",   7'h40, 0, 4'h0, 3'd0, 8'h00,  7'h40, 1, 4'h0, 3'd0, 8'h00, 8'h00);
    drive("far_shift",   7'h78, 0, 4'h3, 3'd0, 8'h00,  7'h04, 0, 4'hD, 3'd0, 8'h00, 8'h40);
    drive("tie_sig_sub", 7'h40, 0, 4'h0, 3'd0, 8'h00,  7'h41, 1, 4'h0, 3'd0, 8'h80, 8'h20);
    drive("zero_op1",    7'h00, 0, 4'h0, 3'd0, 8'h00,  7'h35, 0, 4'hF, 3'd0, 8'hA5, 8'h69);
    drive("zero_op2",    7'h35, 1, 4'hF, 3'd0, 8'hA5,  7'h00, 0, 4'h0, 3'd0, 8'h00, 8'h69);
    drive("diff8",       7'h50, 0, 4'h1, 3'd0, 8'hFF,  7'h40, 0, 4'h0, 3'd0, 8'hFF, 8'h80);
`ifdef ARITH_STICKY_EN
    sticky_exp = 8'h80;
`else
    sticky_exp = 8'h7F;
`endif
    drive("diff9",       7'h51, 0, 4'h1, 3'd1, 8'hFF,  7'h40, 0, 4'h0, 3'd0, 8'hFF, sticky_exp);
`ifdef ARITH_STICKY_EN
    sticky_exp = 8'h61;
`else
    sticky_exp = 8'h60;
`endif
    drive("sticky_lsb",  7'h41, 0, 4'h0, 3'd1, 8'h03,  7'h40, 0, 4'h0, 3'd0, 8'h01, sticky_exp);

    // Reset in flight: load a result, then reset with operands still applied.
    drive("pre_reset",   7'h72, 0, 4'h2, 3'd2, 8'h00,  7'h6E, 0, 4'h1, 3'd7, 8'h00, 8'h48);
    @(negedge clk);
    issue_v = 1'b0;
    #1 reset = 1'b1;
    #1 check_now("reset_async", 8'h00);
    @(posedge clk);
    #1 check_now("reset_hold", 8'h00);
    @(negedge clk);
    reset = 1'b0;
    issue_v = 1'b1;
    q_exp.push_back(8'h48);
    q_name.push_back("after_reset");
    @(negedge clk);
    issue_v = 1'b0;
    repeat (3) @(negedge clk);

    tests++;
    if (q_exp.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results expected 0", q_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
